// File: rtl/macc_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : macc_seq_ctrl_if
// Brief    : Operand stream, multiplier link and result port of the MACC
//            window sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface macc_seq_ctrl_if #(
  parameter int ACC_W = 20
);
  // operand stream
  logic             i_s_valid;
  logic             o_s_ready;
  logic [7:0]       i_s_x;
  logic [7:0]       i_s_y;
  logic [ACC_W-1:0] i_bias;
  // external Booth multiplier
  logic [7:0]       o_mul_x;
  logic [7:0]       o_mul_y;
  logic [14:0]      i_mul_p;
  // result stream and status
  logic             o_m_valid;
  logic             i_m_ready;
  logic [ACC_W-1:0] o_m_data;
  logic             o_m_ovf;
  logic             o_busy;

  // sequencer side
  modport slave (
    input  i_s_valid, i_s_x, i_s_y, i_bias, i_mul_p, i_m_ready,
    output o_s_ready, o_mul_x, o_mul_y, o_m_valid, o_m_data, o_m_ovf, o_busy
  );

  // environment side (operand source, multiplier, result sink)
  modport master (
    output i_s_valid, i_s_x, i_s_y, i_bias, i_mul_p, i_m_ready,
    input  o_s_ready, o_mul_x, o_mul_y, o_m_valid, o_m_data, o_m_ovf, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/macc_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : macc_seq_ctrl
// Brief    : Time-shares one external 8x8 Booth multiplier across a window of
//            KLEN operand pairs and accumulates bias + sum of products with
//            saturation. Three-stage pipeline: operands, product, accumulator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module macc_seq_ctrl #(
  parameter int KLEN  = 9,
  parameter int ACC_W = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  macc_seq_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [7:0]       c_last_beat = 8'(KLEN - 1);
  localparam logic [ACC_W-1:0] c_acc_max   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min   = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cnt;
  logic             r_p1_vld, r_p1_first;
  logic [7:0]       r_mul_x, r_mul_y;
  logic [ACC_W-1:0] r_bias;
  logic             r_p2_vld, r_p2_first;
  logic [ACC_W-1:0] r_prod;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_m_valid;
  logic [ACC_W-1:0] r_m_data;
  logic             r_m_ovf;

  logic             w_s_ready, w_accept, w_first_beat, w_last_beat;
  logic [ACC_W-1:0] w_base, w_sum_sat;
  logic [ACC_W:0]   w_sum;
  logic             w_sat;

  // -128 has no positive counterpart in 8 bits; replacing it keeps every
  // product inside the multiplier's 15-bit signed output.
  function automatic logic [7:0] clamp8(input logic [7:0] v);
    return (v == 8'h80) ? 8'h81 : v;
  endfunction

  // Beats are taken only while collecting a window; clear/reset block them.
  assign w_s_ready    = i_rst_n & ~i_clear & ((r_state == S_IDLE) | (r_state == S_RUN));
  assign w_accept     = bus.i_s_valid & w_s_ready;
  assign w_first_beat = (r_cnt == 8'd0);
  assign w_last_beat  = (r_cnt == c_last_beat);

  // Next-state decode; clear wins over everything else
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
        S_RUN:   if (w_accept && w_last_beat) w_state_nxt = S_DRAIN;
        S_DRAIN: if (!r_p1_vld && !r_p2_vld) w_state_nxt = S_OUT;
        S_OUT:   if (r_m_valid && bus.i_m_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register and beat counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (i_clear)
        r_cnt <= 8'd0;
      else if (w_accept)
        r_cnt <= w_last_beat ? 8'd0 : r_cnt + 8'd1;
    end
  end

  // P1: clamped operand registers driving the multiplier, bias capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p1_vld   <= 1'b0;
      r_p1_first <= 1'b0;
      r_mul_x    <= 8'd0;
      r_mul_y    <= 8'd0;
      r_bias     <= '0;
    end else begin
      r_p1_vld <= w_accept;
      if (w_accept) begin
        r_mul_x    <= clamp8(bus.i_s_x);
        r_mul_y    <= clamp8(bus.i_s_y);
        r_p1_first <= w_first_beat;
        if (w_first_beat)
          r_bias <= bus.i_bias;
      end
    end
  end

  // P2: sign-extended product register with first-of-window tag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p2_vld   <= 1'b0;
      r_p2_first <= 1'b0;
      r_prod     <= '0;
    end else begin
      r_p2_vld <= r_p1_vld & ~i_clear;
      if (r_p1_vld) begin
        r_prod     <= {{(ACC_W-15){bus.i_mul_p[14]}}, bus.i_mul_p};
        r_p2_first <= r_p1_first;
      end
    end
  end

  // Saturating add one bit wider than the accumulator
  assign w_base    = r_p2_first ? r_bias : r_acc;
  assign w_sum     = {w_base[ACC_W-1], w_base} + {r_prod[ACC_W-1], r_prod};
  assign w_sat     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_sum_sat = w_sat ? (w_sum[ACC_W] ? c_acc_min : c_acc_max) : w_sum[ACC_W-1:0];

  // P3: accumulator and sticky overflow, restarted by the first product
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_p2_vld && !i_clear) begin
      r_acc <= w_sum_sat;
      r_ovf <= r_p2_first ? w_sat : (r_ovf | w_sat);
    end
  end

  // Output register: loaded once the drain completes, held under backpressure
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_m_valid <= 1'b0;
    end else if (r_state == S_DRAIN && w_state_nxt == S_OUT) begin
      r_m_valid <= 1'b1;
      r_m_data  <= r_acc;
      r_m_ovf   <= r_ovf;
    end else if (r_m_valid && bus.i_m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign bus.o_s_ready = w_s_ready;
  assign bus.o_mul_x   = r_mul_x;
  assign bus.o_mul_y   = r_mul_y;
  assign bus.o_m_valid = r_m_valid;
  assign bus.o_m_data  = r_m_data;
  assign bus.o_m_ovf   = r_m_ovf;
  assign bus.o_busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_macc_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_macc_seq_ctrl
// Brief    : Scoreboard bench for the MACC window sequencer with a behavioural
//            dot-product model and a combinational multiplier stand-in.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_macc_seq_ctrl;

  localparam int KLEN = 9;
  localparam int AW   = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  always #5 clk = ~clk;

  macc_seq_ctrl_if #(.ACC_W(AW)) bus ();

  macc_seq_ctrl #(.KLEN(KLEN), .ACC_W(AW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (bus)
  );

  // stand-in for the Booth multiplier: plain signed product, low 15 bits
  logic signed [15:0] mul_full;
  assign mul_full    = $signed(bus.o_mul_x) * $signed(bus.o_mul_y);
  assign bus.i_mul_p = mul_full[14:0];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [AW:0] exp_q[$];
  logic [AW:0] mon_e;
  logic [AW:0] direct_e;
  bit          lat_armed = 0;
  int          acc_cyc = 0;
  bit          prev_valid = 0;
  int          xs[KLEN];
  int          ys[KLEN];
  int          bias;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampv(input int v);
    return (v == -128) ? -127 : v;
  endfunction

  // bias + sum of products, clamped to the signed AW-bit range after each add
  function automatic logic [AW:0] model(input int b);
    longint acc = b;
    bit     ovf = 0;
    longint hi  = (longint'(1) <<< (AW - 1)) - 1;
    longint lo  = -(longint'(1) <<< (AW - 1));
    logic [AW-1:0] d;
    for (int i = 0; i < KLEN; i++) begin
      acc = acc + clampv(xs[i]) * clampv(ys[i]);
      if (acc > hi) begin acc = hi; ovf = 1; end
      if (acc < lo) begin acc = lo; ovf = 1; end
    end
    d = acc[AW-1:0];
    return {ovf, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int x, input int y);
    for (int i = 0; i < KLEN; i++) begin
      xs[i] = x;
      ys[i] = y;
    end
  endtask

  // present n beats, optionally with random valid gaps
  task automatic send_beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit done;
      int tries;
      done  = 0;
      tries = 0;
      while (!done) begin
        bus.i_s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.i_s_x     = 8'(xs[i]);
        bus.i_s_y     = 8'(ys[i]);
        bus.i_bias    = AW'(bias);
        @(negedge clk);
        if (bus.i_s_valid && bus.o_s_ready) begin
          done = 1;
          if (i == KLEN - 1) begin
            lat_armed = 1;
            acc_cyc   = cyc;
          end
        end
        tick();
        tries++;
        if (!done && tries > 100) begin
          check("beat_accept_timeout", 0, 1);
          bus.i_s_valid = 1'b0;
          return;
        end
      end
    end
    bus.i_s_valid = 1'b0;
  endtask

  // after the last beat: ready must stay low through DRAIN/OUT
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_busy) begin
      check("s_ready_low_drain_out", bus.o_s_ready, 0);
      n++;
      if (n > 50) begin
        check("idle_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    tick();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_m_valid) begin
      n++;
      if (n > 30) begin
        check("valid_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_window(input int b, input bit gaps);
    bias = b;
    exp_q.push_back(model(b));
    send_beats(KLEN, gaps);
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, bus.o_s_ready, 0);
    check({tag, "_mul_x"},   bus.o_mul_x, 0);
    check({tag, "_mul_y"},   bus.o_mul_y, 0);
    check({tag, "_m_valid"}, bus.o_m_valid, 0);
    check({tag, "_m_data"},  bus.o_m_data, 0);
    check({tag, "_m_ovf"},   bus.o_m_ovf, 0);
    check({tag, "_busy"},    bus.o_busy, 0);
  endtask

  // monitor: latency of each result and scoreboard compare at each handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.o_m_valid && !prev_valid && lat_armed) begin
        check("latency", cyc - (acc_cyc + 1), 3);
        lat_armed = 0;
      end
      if (bus.o_m_valid && bus.i_m_ready && !clear) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_data", $signed(bus.o_m_data), $signed(mon_e[AW-1:0]));
          check("result_ovf", bus.o_m_ovf, mon_e[AW]);
        end
      end
    end
    prev_valid = bus.o_m_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.i_s_valid = 1'b0;
    bus.i_s_x     = 8'd0;
    bus.i_s_y     = 8'd0;
    bus.i_bias    = '0;
    bus.i_m_ready = 1'b1;
    bias          = 0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", bus.o_s_ready, 1);
    tick();

    // unit window
    fill(1, 1);
    run_window(0, 0);

    // bias and signs
    for (int i = 0; i < KLEN; i++) begin
      xs[i] = i + 1;
      ys[i] = 2;
    end
    run_window(-5, 0);
    fill(-3, 7);
    run_window(0, 0);

    // operand clamp and saturation, then a clean window
    fill(-128, -128);
    run_window(0, 0);
    fill(1, 1);
    run_window(0, 0);

    // gaps plus backpressure
    fill(2, 3);
    bias = 0;
    direct_e = model(0);
    exp_q.push_back(direct_e);
    bus.i_m_ready = 1'b0;
    send_beats(KLEN, 1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", bus.o_m_valid, 1);
      check("bp_data_stable", $signed(bus.o_m_data), $signed(direct_e[AW-1:0]));
      check("bp_ovf_stable", bus.o_m_ovf, direct_e[AW]);
      check("bp_s_ready_low", bus.o_s_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.i_m_ready = 1'b1;
    wait_idle();

    // abort after 4 beats; a beat offered during clear must be ignored
    fill(5, 7);
    bias = 100;
    send_beats(4, 0);
    clear         = 1'b1;
    bus.i_s_valid = 1'b1;
    @(negedge clk);
    check("clear_s_ready_low", bus.o_s_ready, 0);
    tick();
    clear         = 1'b0;
    bus.i_s_valid = 1'b0;
    @(negedge clk);
    check("clear_busy_low", bus.o_busy, 0);
    tick();
    fill(1, 1);
    run_window(0, 0);

    // clear while the result waits in OUT
    fill(1, 1);
    bias = 0;
    direct_e = model(0);
    bus.i_m_ready = 1'b0;
    send_beats(KLEN, 0);
    wait_valid();
    check("out_data_before_clear", $signed(bus.o_m_data), $signed(direct_e[AW-1:0]));
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(negedge clk);
    check("out_clear_s_ready_low", bus.o_s_ready, 0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("out_clear_valid_drop", bus.o_m_valid, 0);
    check("out_clear_busy_low", bus.o_busy, 0);
    tick();
    bus.i_m_ready = 1'b1;

    // reset mid-window
    fill(4, 4);
    bias = 7;
    send_beats(6, 0);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_midreset", bus.o_s_ready, 1);
    tick();
    fill(1, 1);
    run_window(3, 0);

    // randomized windows with gaps, full operand range
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < KLEN; i++) begin
        xs[i] = int'($urandom_range(0, 255)) - 128;
        ys[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_window(int'($urandom_range(0, 4000)) - 2000, 1);
    end

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        tick();
        n++;
      end
      if (exp_q.size() != 0) check("scoreboard_drained", exp_q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
